// File: rtl/arf_pkg.sv
// Shared types and width helpers for the ARF error-statistics block.
package arf_pkg;

    // Top-level controller states.
    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StCalc1,
        StCalc2,
        StDone
    } arf_state_e;

    // Signed error width: approx - exact never overflows one extra bit.
    function automatic int unsigned err_w(input int unsigned data_w);
        return data_w + 1;
    endfunction

    // Width of one error squared.
    function automatic int unsigned sq_w(input int unsigned data_w);
        return 2 * err_w(data_w);
    endfunction

    // Signed error-sum width over 2^log2_n samples.
    function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned log2_n);
        return err_w(data_w) + log2_n;
    endfunction

    // Unsigned square-sum width over 2^log2_n samples.
    function automatic int unsigned sqs_w(input int unsigned data_w, input int unsigned log2_n);
        return sq_w(data_w) + log2_n;
    endfunction

endpackage

// File: rtl/arf_err_chan.sv
// One output channel: error, sum / square-sum accumulation, mean and clamped variance.
module arf_err_chan
    import arf_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LOG2_N = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                acc,
    input  logic                calc1,
    input  logic                calc2,
    input  logic [DATA_W-1:0]   approx,
    input  logic [DATA_W-1:0]   exact,
    output logic [DATA_W:0]     mean,
    output logic [2*DATA_W+1:0] variance
);

    localparam int unsigned ERR_W = err_w(DATA_W);
    localparam int unsigned SQ_W  = sq_w(DATA_W);
    localparam int unsigned SUM_W = sum_w(DATA_W, LOG2_N);
    localparam int unsigned SQS_W = sqs_w(DATA_W, LOG2_N);

    logic signed [ERR_W-1:0] err;
    logic signed [SQ_W-1:0]  err_sq;
    logic signed [SUM_W-1:0] sum_q;
    logic        [SQS_W-1:0] sq_q;
    logic signed [ERR_W-1:0] m_q;
    logic        [SQ_W-1:0]  q_q;
    logic signed [SQ_W-1:0]  m_sq;
    logic signed [SQ_W:0]    v_diff;
    logic        [ERR_W-1:0] mean_q;
    logic        [SQ_W-1:0]  var_q;

    assign err    = $signed({approx[DATA_W-1], approx}) - $signed({exact[DATA_W-1], exact});
    assign err_sq = SQ_W'(err) * SQ_W'(err);
    assign m_sq   = SQ_W'(m_q) * SQ_W'(m_q);
    // One extra bit so a negative q - m^2 shows up in the sign.
    assign v_diff = $signed({1'b0, q_q}) - $signed({1'b0, m_sq});

    // Accumulate per sample, then reduce to mean / variance over two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            sq_q   <= '0;
            m_q    <= '0;
            q_q    <= '0;
            mean_q <= '0;
            var_q  <= '0;
        end else begin
            if (clr) begin
                sum_q <= '0;
                sq_q  <= '0;
            end else if (acc) begin
                sum_q <= sum_q + SUM_W'(err);
                sq_q  <= sq_q + SQS_W'($unsigned(err_sq));
            end
            if (calc1) begin
                // Arithmetic shift floors toward -inf; the mean always fits ERR_W.
                m_q <= ERR_W'(sum_q >>> LOG2_N);
                q_q <= SQ_W'(sq_q >> LOG2_N);
            end
            if (calc2) begin
                mean_q <= m_q;
                var_q  <= v_diff[SQ_W] ? '0 : v_diff[SQ_W-1:0];
            end
        end
    end

    assign mean     = mean_q;
    assign variance = var_q;

endmodule

// File: rtl/arf_err_stats.sv
// Windowed error mean / variance of the approximate ARF datapath against the exact one.
module arf_err_stats
    import arf_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LOG2_N = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   approx_27,
    input  logic [DATA_W-1:0]   exact_27,
    input  logic [DATA_W-1:0]   approx_28,
    input  logic [DATA_W-1:0]   exact_28,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_W:0]     mean_27,
    output logic [DATA_W:0]     mean_28,
    output logic [2*DATA_W+1:0] var_27,
    output logic [2*DATA_W+1:0] var_28,
    output logic                busy,
    output logic [LOG2_N-1:0]   sample_cnt
);

    // N-1 is all ones, so the counter wraps to 0 on the last sample by itself.
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    arf_state_e        state_q;
    logic [LOG2_N-1:0] cnt_q;
    logic              accept;
    logic              clr;

    assign in_ready  = (state_q == StAccum);
    assign res_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign accept    = in_valid & in_ready;
    assign clr       = (state_q == StIdle) & start;

    // Window controller and accepted-sample counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StAccum;
                        cnt_q   <= '0;
                    end
                end
                StAccum: begin
                    if (accept) begin
                        cnt_q <= cnt_q + LOG2_N'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= StCalc1;
                        end
                    end
                end
                StCalc1: state_q <= StCalc2;
                StCalc2: state_q <= StDone;
                StDone: begin
                    if (res_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sample_cnt = cnt_q;

    arf_err_chan #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_chan_27 (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .acc      (accept),
        .calc1    (state_q == StCalc1),
        .calc2    (state_q == StCalc2),
        .approx   (approx_27),
        .exact    (exact_27),
        .mean     (mean_27),
        .variance (var_27)
    );

    arf_err_chan #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_chan_28 (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .acc      (accept),
        .calc1    (state_q == StCalc1),
        .calc2    (state_q == StCalc2),
        .approx   (approx_28),
        .exact    (exact_28),
        .mean     (mean_28),
        .variance (var_28)
    );

endmodule

// File: tb/tb_arf_err_stats.sv
// Scoreboard bench for arf_err_stats with N = 4 samples per window.
module tb_arf_err_stats;

    localparam int DW  = 16;
    localparam int L2N = 2;
    localparam int N   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] approx_27, exact_27, approx_28, exact_28;
    logic          res_valid;
    logic          res_ready;
    logic [DW:0]   mean_27, mean_28;
    logic [2*DW+1:0] var_27, var_28;
    logic          busy;
    logic [L2N-1:0] sample_cnt;

    always #5 clk = ~clk;

    arf_err_stats #(
        .DATA_W (DW),
        .LOG2_N (L2N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .approx_27  (approx_27),
        .exact_27   (exact_27),
        .approx_28  (approx_28),
        .exact_28   (exact_28),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .mean_27    (mean_27),
        .mean_28    (mean_28),
        .var_27     (var_27),
        .var_28     (var_28),
        .busy       (busy),
        .sample_cnt (sample_cnt)
    );

    typedef struct packed {
        logic [DW:0]     m27;
        logic [2*DW+1:0] v27;
        logic [DW:0]     m28;
        logic [2*DW+1:0] v28;
    } res_t;

    res_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   a27[N], x27[N], a28[N], x28[N];

    task automatic push_exp(input int m27, input longint v27, input int m28, input longint v28);
        res_t r;
        r.m27 = (DW+1)'(m27);
        r.v27 = (2*DW+2)'(v27);
        r.m28 = (DW+1)'(m28);
        r.v28 = (2*DW+2)'(v28);
        exp_q.push_back(r);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle_gap(input int cycles, input bit poke, input int exp_cnt);
        in_valid = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            if (poke && k == 0) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (poke) begin
            n_vec++;
            if (sample_cnt !== L2N'(exp_cnt) || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL start_in_accum: sample_cnt=%0d in_ready=%b required %0d/1",
                         sample_cnt, in_ready, exp_cnt);
            end
        end
    endtask

    task automatic send_sample(input int i);
        bit got = 0;
        approx_27 = DW'(a27[i]);
        exact_27  = DW'(x27[i]);
        approx_28 = DW'(a28[i]);
        exact_28  = DW'(x28[i]);
        in_valid  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got = 1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic run_window(input bit gaps, input bit poke);
        do_start();
        for (int i = 0; i < N; i++) begin
            if (gaps) idle_gap(i + 1, poke, i);
            send_sample(i);
        end
        n_vec++;
        if (res_valid !== 1'b0 || in_ready !== 1'b0 || sample_cnt !== '0) begin
            n_err++;
            $display("FAIL after_last: res_valid=%b in_ready=%b cnt=%0d required 0/0/0",
                     res_valid, in_ready, sample_cnt);
        end
        @(posedge clk); #1;
        n_vec++;
        if (res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency1: res_valid=%b required 0", res_valid);
        end
        @(posedge clk); #1;
        n_vec++;
        if (res_valid !== 1'b1) begin
            n_err++;
            $display("FAIL latency2: res_valid=%b required 1", res_valid);
        end
    endtask

    task automatic collect(input int hold, input bit poke);
        res_t e;
        bit   got = 0;
        for (int k = 0; k < 20; k++) begin
            if (res_valid === 1'b1) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL res_valid_wait: res_valid=%b required 1", res_valid);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: size=0 required >0");
            return;
        end
        e = exp_q.pop_front();
        for (int h = 0; h <= hold; h++) begin
            n_vec++;
            if (mean_27 !== e.m27) begin
                n_err++;
                $display("FAIL mean_27[%0d]: got %0d required %0d", h,
                         $signed(mean_27), $signed(e.m27));
            end
            n_vec++;
            if (var_27 !== e.v27) begin
                n_err++;
                $display("FAIL var_27[%0d]: got %0d required %0d", h, var_27, e.v27);
            end
            n_vec++;
            if (mean_28 !== e.m28) begin
                n_err++;
                $display("FAIL mean_28[%0d]: got %0d required %0d", h,
                         $signed(mean_28), $signed(e.m28));
            end
            n_vec++;
            if (var_28 !== e.v28) begin
                n_err++;
                $display("FAIL var_28[%0d]: got %0d required %0d", h, var_28, e.v28);
            end
            n_vec++;
            if (res_valid !== 1'b1) begin
                n_err++;
                $display("FAIL res_valid_hold[%0d]: got %b required 1", h, res_valid);
            end
            if (h < hold) begin
                if (poke && h == 0) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_vec++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL transfer: res_valid=%b busy=%b in_ready=%b required 0/0/0",
                     res_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        approx_27 = '0; exact_27 = '0; approx_28 = '0; exact_28 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++;
        if ({in_ready, res_valid, busy} !== 3'b000 || sample_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: rdy/vld/busy=%b%b%b cnt=%0d required 000/0",
                     in_ready, res_valid, busy, sample_cnt);
        end
        n_vec++;
        if (mean_27 !== '0 || mean_28 !== '0 || var_27 !== '0 || var_28 !== '0) begin
            n_err++;
            $display("FAIL reset_results: %0d %0d %0d %0d required all 0",
                     mean_27, mean_28, var_27, var_28);
        end
    endtask

    task automatic test_zero();
        a27 = '{100, -5, 0, 7};
        x27 = a27;
        a28 = '{100, -5, 0, 7};
        x28 = a28;
        push_exp(0, 0, 0, 0);
        run_window(1'b0, 1'b0);
        collect(0, 1'b0);
    endtask

    task automatic test_const_alt();
        x27 = '{10, -20, 300, -4000};
        x28 = '{50, 50, -50, 0};
        for (int i = 0; i < N; i++) begin
            a27[i] = x27[i] + 3;
            a28[i] = x28[i] + ((i % 2 == 0) ? 2 : -2);
        end
        push_exp(3, 0, 0, 4);
        run_window(1'b0, 1'b0);
        collect(0, 1'b0);
    endtask

    task automatic test_floor_clamp();
        x27 = '{0, -100, 1000, 5};
        x28 = '{0, -100, 1000, 5};
        for (int i = 0; i < N; i++) begin
            a27[i] = x27[i] + (i + 1);
            a28[i] = x28[i] - (i + 1);
        end
        push_exp(2, 3, -3, 0);
        run_window(1'b0, 1'b0);
        collect(0, 1'b0);
    endtask

    task automatic test_extremes();
        a27 = '{32767, 32767, 32767, 32767};
        x27 = '{-32768, -32768, -32768, -32768};
        a28 = '{-32768, -32768, -32768, -32768};
        x28 = '{32767, 32767, 32767, 32767};
        push_exp(65535, 0, -65535, 0);
        run_window(1'b0, 1'b0);
        collect(0, 1'b0);
    endtask

    task automatic test_handshake();
        // ch27 errors 0,4,0,4 -> mean 2, q 8, var 4; ch28 errors all 7 -> mean 7, var 0.
        x27 = '{1, 2, 3, 4};
        a27 = '{1, 6, 3, 8};
        x28 = '{-7, 0, 7, 100};
        a28 = '{0, 7, 14, 107};
        push_exp(2, 4, 7, 0);
        run_window(1'b1, 1'b1);
        collect(5, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_transfer: res_valid=%b busy=%b required 0/0", res_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        a27 = '{9, 9, 9, 9};
        x27 = '{0, 0, 0, 0};
        a28 = '{-9, -9, -9, -9};
        x28 = '{0, 0, 0, 0};
        do_start();
        send_sample(0);
        send_sample(1);
        n_vec++;
        if (sample_cnt !== L2N'(2) || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_count: cnt=%0d busy=%b required 2/1", sample_cnt, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || sample_cnt !== '0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_ctrl: busy=%b cnt=%0d in_ready=%b required 0/0/0",
                     busy, sample_cnt, in_ready);
        end
        n_vec++;
        if (mean_27 !== '0 || mean_28 !== '0 || var_27 !== '0 || var_28 !== '0) begin
            n_err++;
            $display("FAIL mid_reset_results: %0d %0d %0d %0d required all 0",
                     mean_27, mean_28, var_27, var_28);
        end
        x27 = '{5, -5, 0, 1000};
        x28 = '{-300, 2, 4, 6};
        for (int i = 0; i < N; i++) begin
            a27[i] = x27[i] + 1;
            a28[i] = x28[i] + 1;
        end
        push_exp(1, 0, 1, 0);
        run_window(1'b0, 1'b0);
        collect(0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero();
        test_const_alt();
        test_floor_clamp();
        test_extremes();
        test_handshake();
        test_reset_mid();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: size=%0d required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
